// File: rtl/toll_lane_sched_pkg.sv
// Shared types and constants for the toll lane scheduler: FSM states,
// tag-code classes and the code classification function.
package toll_lane_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_ALARM,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    CLS_VALID,
    CLS_ALARM,
    CLS_INVALID
  } code_class_t;

  localparam logic [3:0] ALARM_CODE = 4'b1111;
  localparam logic [1:0] EN_ON      = 2'b11;

  function automatic code_class_t classify_code(input logic [3:0] code);
    case (code)
      4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1001, 4'b1010,
      4'b1100, 4'b1101, 4'b1110: return CLS_VALID;
      ALARM_CODE:                return CLS_ALARM;
      default:                   return CLS_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/toll_lane_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr,
// wrapping from the top lane back to lane 0.
module toll_lane_sched_rr_arbiter #(
  parameter int NUM_LANES = 3,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_LANES-1:0] winner_onehot,
  output logic [IDX_W-1:0]     winner_idx
);

  int  idx;
  logic found;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path
    // through this block can leave one unassigned and infer a latch.
    winner_onehot = '0;
    winner_idx    = '0;
    found         = 1'b0;
    idx           = 0;
    for (int off = 0; off < NUM_LANES; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_LANES;
      if (!found && req[idx]) begin
        found              = 1'b1;
        winner_onehot[idx] = 1'b1;
        winner_idx         = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/toll_lane_sched.sv
// Round-robin scheduler sharing one toll output stage between lanes:
// grants a lane, classifies its tag code, drives hipass/en, pulses done.
module toll_lane_sched
  import toll_lane_sched_pkg::*;
#(
  parameter int NUM_LANES    = 3,
  parameter int HOLD_CYCLES  = 8,
  parameter int ALARM_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   req,
  input  logic [4*NUM_LANES-1:0] code_in,
  output logic [NUM_LANES-1:0]   grant,
  output logic [NUM_LANES-1:0]   done,
  output logic                   err,
  output logic [3:0]             hipass_out,
  output logic [1:0]             en_out,
  output logic                   busy
);

  localparam int IDX_W   = $clog2(NUM_LANES);
  localparam int CNT_MAX = (ALARM_CYCLES > HOLD_CYCLES) ? ALARM_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t              state, next_state;
  logic [IDX_W-1:0]    rr_ptr, win_idx_r, win_idx;
  logic [NUM_LANES-1:0] win_onehot;
  logic [3:0]          code_r, win_code;
  logic [CNT_W-1:0]    cnt;
  code_class_t         cur_class;

  toll_lane_sched_rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .req           (req),
    .rr_ptr        (rr_ptr),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx)
  );

  always_comb begin
    win_code = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (win_idx == IDX_W'(i)) win_code = code_in[4*i +: 4];
    end
  end

  assign cur_class = classify_code(code_r);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (|req) next_state = ST_LOAD;
      ST_LOAD: begin
        case (cur_class)
          CLS_VALID: next_state = ST_SHOW;
          CLS_ALARM: next_state = ST_ALARM;
          default:   next_state = ST_RELEASE;
        endcase
      end
      ST_SHOW:    if (cnt == CNT_W'(HOLD_CYCLES - 1))  next_state = ST_RELEASE;
      ST_ALARM:   if (cnt == CNT_W'(ALARM_CYCLES - 1)) next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so they change on the entering edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      win_idx_r  <= '0;
      code_r     <= '0;
      cnt        <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      hipass_out <= '0;
      en_out     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state <= next_state;

      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= win_onehot;
            code_r    <= win_code;
            win_idx_r <= win_idx;
          end
        end
        ST_LOAD:            cnt <= '0;
        ST_SHOW, ST_ALARM:  cnt <= cnt + CNT_W'(1);
        ST_RELEASE: begin
          grant  <= '0;
          rr_ptr <= (win_idx_r == IDX_W'(NUM_LANES - 1)) ? '0 : win_idx_r + IDX_W'(1);
        end
        default: ;
      endcase

      hipass_out <= '0;
      en_out     <= '0;
      done       <= '0;
      err        <= 1'b0;
      case (next_state)
        ST_SHOW: begin
          hipass_out <= code_r;
          en_out     <= EN_ON;
        end
        ST_ALARM:   hipass_out <= ALARM_CODE;
        ST_RELEASE: begin
          done <= grant;
          err  <= (cur_class == CLS_INVALID);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toll_lane_sched.sv
// Directed bench for toll_lane_sched: a per-cycle vector table plus
// hand-written sequences for reset-mid-service and re-arbitration.
module tb_toll_lane_sched;

  localparam int N     = 3;
  localparam int HOLD  = 8;
  localparam int ALARM = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] code_in;
  logic [N-1:0]   grant, done;
  logic           err, busy;
  logic [3:0]     hipass_out;
  logic [1:0]     en_out;

  toll_lane_sched #(
    .NUM_LANES    (N),
    .HOLD_CYCLES  (HOLD),
    .ALARM_CYCLES (ALARM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .code_in    (code_in),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .hipass_out (hipass_out),
    .en_out     (en_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Expected word layout: {grant, done, err, hipass, en, busy}
  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [11:0] code;
    int          n;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [13:0] pk(logic [2:0] g, logic [2:0] d, logic e,
                                     logic [3:0] h, logic [1:0] en, logic b);
    return {g, d, e, h, en, b};
  endfunction

  function automatic void add(logic r, logic [2:0] rq, logic [11:0] c, int n,
                              logic [13:0] exp);
    vec_t v;
    v.rst  = r;
    v.req  = rq;
    v.code = c;
    v.n    = n;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs();
    return {grant, done, err, hipass_out, en_out, busy};
  endfunction

  // Steps until done is seen or the budget runs out; returns cycles taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done == '0 && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [2:0] g;
    logic [13:0] zero;
    int n;

    zero = '0;
    rst = 1'b1;
    req = '0;
    code_in = '0;

    // Reset with all lanes requesting, then idle with no requests.
    add(1, 3'b111, 12'h555, 2, zero);
    add(0, 3'b000, 12'h555, 2, zero);

    // Single valid code on lane 1.
    add(0, 3'b010, 12'h050, 1,    pk(3'b010, 3'b000, 0, 4'h0, 2'b00, 1));
    add(0, 3'b000, 12'h050, HOLD, pk(3'b010, 3'b000, 0, 4'h5, 2'b11, 1));
    add(0, 3'b000, 12'h050, 1,    pk(3'b010, 3'b010, 0, 4'h0, 2'b00, 1));
    add(0, 3'b000, 12'h050, 1,    zero);

    // Round-robin over all three lanes with requests held.
    add(1, 3'b000, 12'h888, 1, zero);
    for (int k = 0; k < 4; k++) begin
      g = '0;
      g[k % 3] = 1'b1;
      add(0, 3'b111, 12'h888, 1,    pk(g, 3'b000, 0, 4'h0, 2'b00, 1));
      add(0, 3'b111, 12'h888, HOLD, pk(g, 3'b000, 0, 4'h8, 2'b11, 1));
      add(0, 3'b111, 12'h888, 1,    pk(g, g,      0, 4'h0, 2'b00, 1));
      add(0, 3'b111, 12'h888, 1,    zero);
    end

    // Alarm code on lane 2.
    add(1, 3'b000, 12'hF00, 1,     zero);
    add(0, 3'b100, 12'hF00, 1,     pk(3'b100, 3'b000, 0, 4'h0, 2'b00, 1));
    add(0, 3'b000, 12'hF00, ALARM, pk(3'b100, 3'b000, 0, 4'hF, 2'b00, 1));
    add(0, 3'b000, 12'hF00, 1,     pk(3'b100, 3'b100, 0, 4'h0, 2'b00, 1));
    add(0, 3'b000, 12'hF00, 1,     zero);

    // Invalid code on lane 0: LOAD straight to RELEASE with err.
    add(1, 3'b000, 12'h003, 1, zero);
    add(0, 3'b001, 12'h003, 1, pk(3'b001, 3'b000, 0, 4'h0, 2'b00, 1));
    add(0, 3'b000, 12'h003, 1, pk(3'b001, 3'b001, 1, 4'h0, 2'b00, 1));
    add(0, 3'b000, 12'h003, 1, zero);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      req     = vecs[i].req;
      code_in = vecs[i].code;
      for (int c = 0; c < vecs[i].n; c++) begin
        step();
        check($sformatf("row%0d cyc%0d {grant,done,err,hipass,en,busy}", i, c),
              32'(obs()), 32'(vecs[i].exp));
      end
    end

    // Complete a lane 1 service so rr_ptr moves to 2.
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0; req = 3'b010; code_in = 12'h050;
    step();
    check("seq lane1 grant", 32'(grant), 32'(3'b010));
    req = '0;
    wait_done(n);
    check("seq lane1 done latency", n, HOLD + 1);
    check("seq lane1 done", 32'(done), 32'(3'b010));
    step();
    check("seq idle busy", 32'(busy), 0);

    // Second lane 1 service: code change ignored, then reset on SHOW cycle 4.
    req = 3'b010;
    step();
    check("seq2 grant", 32'(grant), 32'(3'b010));
    req = '0;
    step();
    code_in = 12'h0F0;
    step();
    step();
    step();
    check("seq2 hipass after code change", 32'(hipass_out), 32'h5);
    check("seq2 en during show", 32'(en_out), 32'(2'b11));
    rst = 1'b1;
    step();
    check("reset mid-SHOW outputs", 32'(obs()), 0);

    // rr_ptr must be 0 after reset: lane 1 beats lane 2.
    rst = 1'b0; req = 3'b110; code_in = 12'h880;
    step();
    check("post-reset rr winner", 32'(grant), 32'(3'b010));
    wait_done(n);
    check("post-reset done latency", n, HOLD + 1);
    check("post-reset done", 32'(done), 32'(3'b010));
    step();
    check("post-reset idle gap", 32'(grant), 0);
    step();
    check("rearb lowest priority", 32'(grant), 32'(3'b100));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
